// File: rtl/sched_pkg.sv
// Shared types and helpers for the sample scheduler.
//   state_t  : FSM state encoding (IDLE, ADC_WAIT, PROC_WAIT)
//   sat8_inc : 8-bit increment that sticks at 255 instead of wrapping
package sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADC_WAIT  = 2'd1,
        ST_PROC_WAIT = 2'd2
    } state_t;

    function automatic logic [7:0] sat8_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sample_scheduler_if.sv
// Sample path bundle between the scheduler and the ADC / processor / DAC blocks.
//   adc_start   : scheduler -> ADC, start a conversion
//   adc_valid   : ADC -> scheduler, adc_data holds a converted sample
//   adc_data    : converted sample
//   proc_start  : scheduler -> processor, proc_data holds a new sample
//   proc_data   : sample held for the processor until the next capture
//   proc_done   : processor -> scheduler, proc_result is valid
//   proc_result : processed sample
//   dac_start   : scheduler -> DAC/PWM, load dac_data
//   dac_data    : sample for the DAC/PWM, held until the next update
//
// Handshake: every *_start / *_valid / *_done line is a one-cycle strobe with
// no ready/backpressure. Data qualified by a strobe is valid in the same cycle
// as the strobe; the receiver must take it in that cycle. proc_data and
// dac_data additionally hold their value until the next update.
interface sample_scheduler_if #(
    parameter int DW = 10
);
    logic          adc_start;
    logic          adc_valid;
    logic [DW-1:0] adc_data;
    logic          proc_start;
    logic [DW-1:0] proc_data;
    logic          proc_done;
    logic [DW-1:0] proc_result;
    logic          dac_start;
    logic [DW-1:0] dac_data;

    modport master (
        output adc_start,
        input  adc_valid,
        input  adc_data,
        output proc_start,
        output proc_data,
        input  proc_done,
        input  proc_result,
        output dac_start,
        output dac_data
    );

    modport slave (
        input  adc_start,
        output adc_valid,
        output adc_data,
        input  proc_start,
        input  proc_data,
        output proc_done,
        output proc_result,
        input  dac_start,
        input  dac_data
    );
endinterface

// File: rtl/tick_divider.sv
// Sampling tick generator.
//   clk    : system clock
//   rst_n  : synchronous reset, active low
//   enable : 1 = count; 0 = hold the divider at 0
//   tick   : high for one cycle every CLK_DIV+1 enabled cycles
module tick_divider #(
    parameter int CLK_DIV = 4999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    localparam int DIVW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [DIVW-1:0] DIV_MAX = DIVW'(CLK_DIV);

    logic [DIVW-1:0] div;

    assign tick = enable && (div == DIV_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
        end else if (!enable || tick) begin
            div <= '0;
        end else begin
            div <= div + DIVW'(1);
        end
    end
endmodule

// File: rtl/sample_scheduler.sv
// Sequences one ADC -> processor -> DAC pass per sampling tick and keeps
// overrun / timeout diagnostics.
//   sysclk      : system clock
//   rst_n       : synchronous reset, active low
//   enable      : 1 = run sampling; 0 = finish the current pass, then stop
//   bus         : sample path bundle (master side)
//   busy        : a pass is in progress
//   overrun_cnt : ticks dropped while busy, saturating
//   timeout_cnt : passes aborted on wait timeout, saturating
//   state_dbg   : current FSM state
module sample_scheduler
    import sched_pkg::*;
#(
    parameter int DW      = 10,
    parameter int CLK_DIV = 4999,
    parameter int TMO     = 2047
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                enable,
    sample_scheduler_if.master  bus,
    output logic                busy,
    output logic [7:0]          overrun_cnt,
    output logic [7:0]          timeout_cnt,
    output state_t              state_dbg
);
    localparam int WW = (TMO < 1) ? 1 : $clog2(TMO + 1);
    localparam logic [WW-1:0] TMO_W = WW'(TMO);

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic          tick;
    logic          tmo_hit;
    logic          adc_go;
    logic          proc_go;
    logic          done_go;
    logic          abort;
    logic [DW-1:0] adc_sample;
    logic [DW-1:0] proc_sample;

    assign adc_sample  = bus.adc_data;
    assign proc_sample = bus.proc_result;

    tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_divider (
        .clk    (sysclk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // wait_cnt is the index of the current cycle within the wait state.
    assign tmo_hit = (wait_cnt == TMO_W);

    // Next state and one-cycle event decisions. valid/done is tested before
    // the timeout so a response arriving on the last allowed cycle is kept.
    always_comb begin
        state_nxt = state;
        adc_go    = 1'b0;
        proc_go   = 1'b0;
        done_go   = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_nxt = ST_ADC_WAIT;
                    adc_go    = 1'b1;
                end
            end
            ST_ADC_WAIT: begin
                if (bus.adc_valid) begin
                    state_nxt = ST_PROC_WAIT;
                    proc_go   = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                    abort     = 1'b1;
                end
            end
            ST_PROC_WAIT: begin
                if (bus.proc_done) begin
                    state_nxt = ST_IDLE;
                    done_go   = 1'b1;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                    abort     = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            bus.adc_start  <= 1'b0;
            bus.proc_start <= 1'b0;
            bus.dac_start  <= 1'b0;
            bus.proc_data  <= '0;
            bus.dac_data   <= '0;
            overrun_cnt    <= '0;
            timeout_cnt    <= '0;
        end else begin
            state          <= state_nxt;
            bus.adc_start  <= adc_go;
            bus.proc_start <= proc_go;
            // An aborted pass still loads the DAC so it re-holds the last value.
            bus.dac_start  <= done_go || abort;
            if (proc_go) begin
                bus.proc_data <= adc_sample;
            end
            if (done_go) begin
                bus.dac_data <= proc_sample;
            end
            // Restart the wait count on every state change.
            if (state == ST_IDLE || state_nxt != state) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WW'(1);
            end
            if (tick && state != ST_IDLE) begin
                overrun_cnt <= sat8_inc(overrun_cnt);
            end
            if (abort) begin
                timeout_cnt <= sat8_inc(timeout_cnt);
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sample_scheduler.sv
module tb_sample_scheduler;
    import sched_pkg::*;

    localparam int DW      = 10;
    localparam int CLK_DIV = 9;
    localparam int TMO     = 15;
    localparam int NEVER   = 100000;

    // ---------------- clock / reset / DUT ----------------
    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       busy;
    logic [7:0] overrun_cnt;
    logic [7:0] timeout_cnt;
    state_t     state_dbg;

    sample_scheduler_if #(.DW(DW)) bus();

    sample_scheduler #(
        .DW      (DW),
        .CLK_DIV (CLK_DIV),
        .TMO     (TMO)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus         (bus.master),
        .busy        (busy),
        .overrun_cnt (overrun_cnt),
        .timeout_cnt (timeout_cnt),
        .state_dbg   (state_dbg)
    );

    always #5 sysclk = ~sysclk;

    // ---------------- bench state ----------------
    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    logic          in_rst_n  = 1'b0;
    logic          in_enable = 1'b0;
    int            adc_dly_fix  = -1;
    int            proc_dly_fix = -1;
    logic [DW-1:0] result_fix   = '0;
    bit            result_rand  = 1'b0;
    bit            noise_en     = 1'b0;
    int            adc_fire  = -1;
    int            proc_fire = -1;

    // reference model: phase 0 = idle, 1 = waiting for ADC, 2 = waiting for processor
    int            m_phase = 0;
    int            m_entry = 0;
    int            m_run   = 0;
    bit            e_adc_start  = 1'b0;
    bit            e_proc_start = 1'b0;
    bit            e_dac_start  = 1'b0;
    logic [DW-1:0] e_proc_data  = '0;
    logic [DW-1:0] e_dac_data   = '0;
    int            e_ovr = 0;
    int            e_tmo = 0;

    logic [DW-1:0] exp_q[$];

    // observed DUT events
    int last_adc  = -1000;
    int last_proc = -1000;
    int last_dac  = -1000;
    int n_adc = 0;
    int n_dac = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int pick_dly(input int fix);
        int r;
        if (fix >= 0) return fix;
        r = $urandom_range(0, 9);
        case (r)
            0:       return 0;
            1:       return TMO;
            2:       return TMO + 1;
            3:       return TMO + 10;
            default: return $urandom_range(1, TMO - 1);
        endcase
    endfunction

    // Advance the model by the inputs of cycle 'cyc'; results apply to cyc+1.
    task automatic model_step();
        bit tick;
        e_adc_start  = 1'b0;
        e_proc_start = 1'b0;
        e_dac_start  = 1'b0;
        if (!rst_n) begin
            m_phase     = 0;
            m_run       = 0;
            e_proc_data = '0;
            e_dac_data  = '0;
            e_ovr       = 0;
            e_tmo       = 0;
            return;
        end
        // tick on every (CLK_DIV+1)-th consecutive enabled cycle
        tick  = enable && ((m_run % (CLK_DIV + 1)) == CLK_DIV);
        m_run = enable ? m_run + 1 : 0;
        if (m_phase != 0 && tick && e_ovr < 255) e_ovr++;
        if (m_phase == 0) begin
            if (tick) begin
                m_phase     = 1;
                m_entry     = cyc + 1;
                e_adc_start = 1'b1;
            end
        end else if (m_phase == 1 && bus.adc_valid) begin
            e_proc_data  = bus.adc_data;
            e_proc_start = 1'b1;
            m_phase      = 2;
            m_entry      = cyc + 1;
        end else if (m_phase == 2 && bus.proc_done) begin
            e_dac_data  = bus.proc_result;
            e_dac_start = 1'b1;
            m_phase     = 0;
        end else if (cyc - m_entry == TMO) begin
            if (e_tmo < 255) e_tmo++;
            e_dac_start = 1'b1;
            m_phase     = 0;
        end
    endtask

    // ---------------- one clock cycle: compare, drive, predict ----------------
    task automatic cycle();
        @(negedge sysclk);
        cyc++;
        chk("adc_start",   int'(bus.adc_start),  int'(e_adc_start));
        chk("proc_start",  int'(bus.proc_start), int'(e_proc_start));
        chk("dac_start",   int'(bus.dac_start),  int'(e_dac_start));
        chk("proc_data",   int'(bus.proc_data),  int'(e_proc_data));
        chk("dac_data",    int'(bus.dac_data),   int'(e_dac_data));
        chk("busy",        int'(busy),           int'(m_phase != 0));
        chk("overrun_cnt", int'(overrun_cnt),    e_ovr);
        chk("timeout_cnt", int'(timeout_cnt),    e_tmo);

        if (e_dac_start) exp_q.push_back(e_dac_data);
        if (bus.dac_start === 1'b1) begin
            if (exp_q.size() == 0) chk("dac_extra", int'(bus.dac_start), 0);
            else                   chk("dac_queue", int'(bus.dac_data), int'(exp_q.pop_front()));
        end

        if (bus.adc_start === 1'b1)  begin last_adc = cyc; n_adc++; end
        if (bus.proc_start === 1'b1) last_proc = cyc;
        if (bus.dac_start === 1'b1)  begin last_dac = cyc; n_dac++; end

        // responder: react to the strobes the model says are present now
        if (e_adc_start)  adc_fire  = cyc + pick_dly(adc_dly_fix);
        if (e_proc_start) proc_fire = cyc + pick_dly(proc_dly_fix);
        bus.adc_valid   = (cyc == adc_fire) ||
                          (noise_en && m_phase != 1 && $urandom_range(0, 3) == 0);
        bus.adc_data    = DW'($urandom);
        bus.proc_done   = (cyc == proc_fire) ||
                          (noise_en && m_phase != 2 && $urandom_range(0, 3) == 0);
        bus.proc_result = result_rand ? DW'($urandom) : result_fix;
        rst_n  = in_rst_n;
        enable = in_enable;
        model_step();
    endtask

    // Run one directed pass: enable long enough for exactly one tick, then idle.
    task automatic one_pass(output int c0, input int idle_cycles);
        adc_fire  = -1;
        proc_fire = -1;
        c0 = cyc + 1;
        in_enable = 1'b1;
        repeat (CLK_DIV + 2) cycle();
        in_enable = 1'b0;
        repeat (idle_cycles) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int n_dac0;
        int n_adc0;
        bus.adc_valid   = 1'b0;
        bus.adc_data    = '0;
        bus.proc_done   = 1'b0;
        bus.proc_result = '0;

        // reset state
        in_rst_n = 1'b0;
        repeat (3) cycle();
        in_rst_n = 1'b1;
        repeat (2) cycle();
        chk("rst_dac_data", int'(bus.dac_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun_cnt), 0);

        // normal pass, enable dropped mid-pass
        adc_dly_fix = 3; proc_dly_fix = 2; result_fix = 10'h2A5;
        n_adc0 = n_adc; n_dac0 = n_dac;
        one_pass(c0, 25);
        chk("pass_adc_latency", last_adc - c0, 10);
        chk("pass_proc_latency", last_proc - last_adc, 4);
        chk("pass_length", last_dac - last_adc, 7);
        chk("pass_dac_data", int'(bus.dac_data), 'h2A5);
        chk("pass_adc_count", n_adc - n_adc0, 1);
        chk("pass_dac_count", n_dac - n_dac0, 1);
        chk("pass_overrun", int'(overrun_cnt), 0);

        // ADC never answers: abort with sample-and-hold
        adc_dly_fix = NEVER;
        one_pass(c0, 25);
        chk("tmo_tick_to_dac", last_dac - (c0 + CLK_DIV), 17);
        chk("tmo_count", int'(timeout_cnt), 1);
        chk("tmo_dac_hold", int'(bus.dac_data), 'h2A5);

        // adc_valid on the last allowed cycle wins over the timeout
        adc_dly_fix = TMO; proc_dly_fix = 1; result_fix = 10'h13C;
        one_pass(c0, 25);
        chk("edge_proc_latency", last_proc - last_adc, 16);
        chk("edge_timeout_cnt", int'(timeout_cnt), 1);
        chk("edge_dac_data", int'(bus.dac_data), 'h13C);

        // reset while waiting for the processor
        adc_dly_fix = 2; proc_dly_fix = 10;
        adc_fire = -1; proc_fire = -1;
        n_dac0 = n_dac;
        c0 = cyc + 1;
        in_enable = 1'b1;
        repeat (CLK_DIV + 2) cycle();
        in_enable = 1'b0;
        repeat (5) cycle();
        in_rst_n = 1'b0;
        cycle();
        in_rst_n = 1'b1;
        repeat (20) cycle();
        chk("mid_rst_no_dac", n_dac - n_dac0, 0);
        chk("mid_rst_dac_data", int'(bus.dac_data), 0);
        chk("mid_rst_timeout", int'(timeout_cnt), 0);
        adc_dly_fix = 1; proc_dly_fix = 1; result_fix = 10'h2A5;
        one_pass(c0, 20);
        chk("after_rst_length", last_dac - last_adc, 4);
        chk("after_rst_dac_data", int'(bus.dac_data), 'h2A5);

        // long overrunning run: both counters saturate
        adc_dly_fix = NEVER;
        in_enable = 1'b1;
        repeat (5600) cycle();
        chk("sat_overrun", int'(overrun_cnt), 255);
        chk("sat_timeout", int'(timeout_cnt), 255);

        // randomized traffic
        in_rst_n = 1'b0;
        repeat (2) cycle();
        in_rst_n = 1'b1;
        adc_dly_fix = -1; proc_dly_fix = -1;
        result_rand = 1'b1; noise_en = 1'b1;
        repeat (4000) begin
            in_enable = ($urandom_range(0, 19) != 0);
            in_rst_n  = ($urandom_range(0, 399) != 0);
            cycle();
        end
        in_rst_n = 1'b1; in_enable = 1'b0; noise_en = 1'b0;
        repeat (40) cycle();
        chk("dac_queue_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
